onehot_index_decoder: RTL and testbench

Registered index-to-one-hot decoder with a valid/ready handshake. It is the inverse of the team's 8-input priority encoder.
- Accepts a 3-bit index and returns the corresponding one-hot vector one cycle later.
- Keeps a sticky mask of every bit decoded since the last clear.
- Counts accepted transactions.
- Sits downstream of the priority encoder in the request/grant path. It turns a selected index back into a per-line grant and tracks which lines have been served.

---
 rtl/onehot_index_decoder.sv | 72 +++++++
 tb/tb_onehot_index_decoder.sv | 213 +++++++++++++++++++++
 2 files changed

// File: rtl/onehot_index_decoder.sv
// Registered index-to-one-hot decoder with valid/ready handshake.
// Tracks a sticky mask of decoded lines and counts accepted inputs.
module onehot_index_decoder #(
    parameter int N = 3
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic [N-1:0]        in_code,
    input  logic                in_en,
    output logic                out_valid,
    input  logic                out_ready,
    output logic [(1<<N)-1:0]   out_onehot,
    output logic [(1<<N)-1:0]   seen_mask,
    input  logic                seen_clr,
    output logic [7:0]          acc_count
);

    localparam int W = 1 << N;

    logic         accept;
    logic [W-1:0] dec;

    // Single-stage pipeline: room when empty or when the slot drains now.
    always_comb begin
        in_ready = !out_valid || out_ready;
        accept   = in_valid && in_ready;
    end

    // Decode the index; a disabled request yields an all-zero grant.
    always_comb begin
        dec = '0;
        if (in_en) begin
            dec[in_code] = 1'b1;
        end
    end

    // Output slot: load on accept, empty on drain, hold on stall.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid  <= 1'b0;
            out_onehot <= '0;
        end else if (accept) begin
            out_valid  <= 1'b1;
            out_onehot <= dec;
        end else if (out_ready) begin
            out_valid  <= 1'b0;
        end
    end

    // Served-line mask: clear takes effect before a same-cycle set.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            seen_mask <= '0;
        end else if (seen_clr) begin
            seen_mask <= accept ? dec : '0;
        end else if (accept) begin
            seen_mask <= seen_mask | dec;
        end
    end

    // Accept counter, wraps modulo 256, independent of mask clears.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc_count <= 8'd0;
        end else if (accept) begin
            acc_count <= acc_count + 8'd1;
        end
    end

endmodule

// File: tb/tb_onehot_index_decoder.sv
// Directed-vector bench for onehot_index_decoder.
// Checks decode, handshake, mask, counter and async reset.
module tb_onehot_index_decoder;

    logic       clk;
    logic       rst_n;
    logic       in_valid;
    logic       in_ready;
    logic [2:0] in_code;
    logic       in_en;
    logic       out_valid;
    logic       out_ready;
    logic [7:0] out_onehot;
    logic [7:0] seen_mask;
    logic       seen_clr;
    logic [7:0] acc_count;

    int n_cmp;
    int n_err;

    onehot_index_decoder #(.N(3)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_code    (in_code),
        .in_en      (in_en),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_onehot (out_onehot),
        .seen_mask  (seen_mask),
        .seen_clr   (seen_clr),
        .acc_count  (acc_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    initial begin
        n_cmp     = 0;
        n_err     = 0;
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        in_code   = 3'd0;
        in_en     = 1'b1;
        out_ready = 1'b0;
        seen_clr  = 1'b0;

        // reset state
        cyc();
        cyc();
        chk("rst_valid", 32'(out_valid), 32'd0);
        chk("rst_ready", 32'(in_ready), 32'd1);
        chk("rst_onehot", 32'(out_onehot), 32'h00);
        chk("rst_mask", 32'(seen_mask), 32'h00);
        chk("rst_count", 32'(acc_count), 32'd0);
        rst_n = 1'b1;

        // decode sweep, back-to-back
        out_ready = 1'b1;
        in_valid  = 1'b1;
        in_en     = 1'b1;
        for (int i = 0; i < 8; i++) begin
            in_code = 3'(i);
            cyc();
            chk("sweep_onehot", 32'(out_onehot), 32'(1 << i));
            chk("sweep_valid", 32'(out_valid), 32'd1);
        end
        in_valid = 1'b0;
        chk("sweep_count", 32'(acc_count), 32'd8);
        chk("sweep_mask", 32'(seen_mask), 32'hFF);
        cyc();
        chk("drain_valid", 32'(out_valid), 32'd0);
        chk("drain_hold", 32'(out_onehot), 32'h80);
        seen_clr = 1'b1;
        cyc();
        seen_clr = 1'b0;
        chk("lone_clr0", 32'(seen_mask), 32'h00);
        chk("clr_count", 32'(acc_count), 32'd8);

        // fresh start for backpressure
        rst_n = 1'b0;
        #1;
        chk("rst2_count", 32'(acc_count), 32'd0);
        cyc();
        rst_n = 1'b1;

        in_valid  = 1'b1;
        in_code   = 3'd3;
        out_ready = 1'b1;
        cyc();
        chk("bp_first", 32'(out_onehot), 32'h08);
        chk("bp_cnt1", 32'(acc_count), 32'd1);
        in_code   = 3'd6;
        out_ready = 1'b0;
        #1;
        chk("bp_ready0", 32'(in_ready), 32'd0);
        for (int i = 0; i < 3; i++) begin
            cyc();
            chk("bp_hold", 32'(out_onehot), 32'h08);
            chk("bp_hvalid", 32'(out_valid), 32'd1);
            chk("bp_hready", 32'(in_ready), 32'd0);
            chk("bp_hcnt", 32'(acc_count), 32'd1);
        end
        out_ready = 1'b1;
        #1;
        chk("bp_ready1", 32'(in_ready), 32'd1);
        cyc();
        chk("bp_next", 32'(out_onehot), 32'h40);
        chk("bp_cnt2", 32'(acc_count), 32'd2);
        chk("bp_valid", 32'(out_valid), 32'd1);

        // stall holding 8'h20, then async reset
        in_code = 3'd5;
        cyc();
        chk("st_load", 32'(out_onehot), 32'h20);
        in_valid  = 1'b0;
        out_ready = 1'b0;
        cyc();
        chk("st_valid", 32'(out_valid), 32'd1);
        chk("st_onehot", 32'(out_onehot), 32'h20);
        #2;
        rst_n = 1'b0;
        #1;
        chk("ar_valid", 32'(out_valid), 32'd0);
        chk("ar_onehot", 32'(out_onehot), 32'h00);
        chk("ar_mask", 32'(seen_mask), 32'h00);
        chk("ar_count", 32'(acc_count), 32'd0);
        chk("ar_ready", 32'(in_ready), 32'd1);
        cyc();
        rst_n = 1'b1;
        out_ready = 1'b1;
        cyc();
        chk("ar_post1", 32'(out_valid), 32'd0);
        cyc();
        chk("ar_post2", 32'(out_valid), 32'd0);

        // disabled decode
        in_valid = 1'b1;
        in_en    = 1'b1;
        in_code  = 3'd1;
        cyc();
        chk("dis_pre", 32'(seen_mask), 32'h02);
        in_en   = 1'b0;
        in_code = 3'd5;
        cyc();
        chk("dis_onehot", 32'(out_onehot), 32'h00);
        chk("dis_valid", 32'(out_valid), 32'd1);
        chk("dis_mask", 32'(seen_mask), 32'h02);
        chk("dis_count", 32'(acc_count), 32'd2);

        // clear collision
        in_en    = 1'b1;
        in_code  = 3'd0;
        seen_clr = 1'b1;
        cyc();
        chk("cc_set01", 32'(seen_mask), 32'h01);
        seen_clr = 1'b0;
        in_code  = 3'd7;
        cyc();
        chk("cc_pre", 32'(seen_mask), 32'h81);
        seen_clr = 1'b1;
        in_code  = 3'd2;
        cyc();
        chk("cc_coll", 32'(seen_mask), 32'h04);
        chk("cc_onehot", 32'(out_onehot), 32'h04);
        in_valid = 1'b0;
        cyc();
        seen_clr = 1'b0;
        chk("cc_lone", 32'(seen_mask), 32'h00);
        chk("cc_count", 32'(acc_count), 32'd5);

        // counter wrap over 257 accepts
        rst_n = 1'b0;
        cyc();
        rst_n    = 1'b1;
        in_valid = 1'b1;
        in_en    = 1'b1;
        in_code  = 3'd4;
        cyc();
        chk("wr_first", 32'(seen_mask), 32'h10);
        in_en = 1'b0;
        for (int i = 0; i < 255; i++) begin
            in_code = 3'(i);
            cyc();
        end
        chk("wr_zero", 32'(acc_count), 32'd0);
        chk("wr_mask0", 32'(seen_mask), 32'h10);
        cyc();
        in_valid = 1'b0;
        chk("wr_one", 32'(acc_count), 32'd1);
        chk("wr_mask1", 32'(seen_mask), 32'h10);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_err);
        $finish;
    end

endmodule
